key_updown_counter: RTL and testbench
=====================================

Name: key_updown_counter

Overview:
Parametrised successor to the single-key decrementing LED counter. Three push-buttons (up, down, clear) are synchronised and debounced inside the block, entirely on CLK; no logic is clocked by a key. Each debounced press steps a WIDTH-bit count, which drives the LED bank directly. Adds selectable wrap or saturate at the count limits, plus carry and borrow event pulses for chaining or display logic.

Parameters:
WIDTH, 8, count and LED width in bits (legal range 2..32).
DEB_CYCLES, 20000, consecutive CLK edges a synchronised key must differ from its debounced state before that state flips (legal range 1..2^20).
INIT_VALUE, 8'hFF, value loaded by Reset and by a clear press; must fit in WIDTH.
SATURATE, 0, 0 = wrap at the limits, 1 = hold at the limits.
KEY_ACTIVE_LOW, 1, 1 = a key reads 0 when pressed, 0 = a key reads 1 when pressed.

Ports:
CLK  input  1  system clock; all state advances on the rising edge.
Reset  input  1  asynchronous, active-low reset.
KeyUp  input  1  raw, bouncy increment button.
KeyDown  input  1  raw, bouncy decrement button.
KeyClr  input  1  raw, bouncy clear button.
LED  output  WIDTH  current count (registered).
Carry  output  1  one-cycle pulse when an increment hits the upper limit.
Borrow  output  1  one-cycle pulse when a decrement hits the lower limit.

Behaviour:
- Reset low, asynchronous: LED=INIT_VALUE, Carry=0, Borrow=0. Both sync flops of each key load the released level. Debounced states are released. Debounce counters are 0.
- Each key is independent: 2-flop synchroniser (sync1, then sync2), then a debouncer.
- Debouncer: on each edge, if sync2 equals the debounced state, the counter clears to 0. Otherwise the counter increments.
- Debouncer flip: on the edge where the counter would reach DEB_CYCLES, the debounced state flips and the counter clears.
- Press event: the debounced state goes released to pressed. It is used combinationally and acts on that same edge.
- Release is debounced identically. A new press cannot count until a debounced release has occurred.
- Latency: the raw level is first captured at edge 1 and held stable. LED/Carry/Borrow update at edge 2+DEB_CYCLES. Any bounce restarts the count.
- A raw pulse shorter than DEB_CYCLES edges (after synchronisation) has no effect.
- Priority on the same edge: clear > (up and down together) > up alone > down alone.
- Clear press: LED=INIT_VALUE, no Carry/Borrow.
- Up and down pressed on the same edge: no change, no pulses.
- Up at LED=2^WIDTH-1:
  - SATURATE=0: LED becomes 0 and Carry=1.
  - SATURATE=1: LED holds at max and Carry=1.
- Up otherwise: LED+1 modulo 2^WIDTH.
- Down at LED=0:
  - SATURATE=0: LED becomes 2^WIDTH-1 and Borrow=1.
  - SATURATE=1: LED holds at 0 and Borrow=1.
- Down otherwise: LED-1.
- Carry and Borrow are registered and high for exactly one cycle. They are never high together.
- Reset asserted mid-debounce or mid-pulse: everything returns to reset values immediately; no pending press survives.
- A key held down through Reset release is seen as a fresh press: it counts once after 2+DEB_CYCLES edges.
- Arithmetic is unsigned WIDTH-bit; no intermediate wider than WIDTH+1.

Test Plan:
- Reset defaults: WIDTH=4, DEB_CYCLES=4, INIT_VALUE=4'hF, Reset low then high -> LED=F, Carry=0, Borrow=0 immediately, with no CLK needed.
- Down press, clean: KeyDown low, held stable 10 cycles -> LED F->E at exactly edge 6 after capture, and once only. Then release and 5 more presses -> LED=9.
- Bounce rejection: KeyDown toggled every 2 cycles for 20 cycles, then held low -> exactly one decrement, 6 edges after the last toggle. A 3-cycle glitch produces no change.
- Wrap mode: LED=1 with 2 down presses -> 0 then F, with a Borrow pulse of 1 cycle at the F transition. Up at F -> 0 with Carry.
- Saturate mode: SATURATE=1, INIT_VALUE=4'h0, down press -> LED stays 0 and Borrow pulses. 16 up presses -> LED=F, with a Carry pulse on the 16th only.
- Priority and reset: up+down debounced on the same edge -> no change. Clear+up on the same edge -> LED=INIT_VALUE. Reset pulsed at debounce count 2 -> no count afterwards unless the key is still held, in which case there is one count 6 edges after release of Reset.

Source files
------------

// File: rtl/key_updown_counter.sv
// key_updown_counter: three debounced push-buttons (up, down, clear) step a
// WIDTH-bit count that drives the LED bank directly. The count either wraps
// or saturates at its limits, with one-cycle Carry/Borrow event pulses.
// Every flop is clocked by CLK; raw keys are only ever sampled as data.

// Per-key front end: 2-flop synchroniser followed by a debouncer. 'press'
// is a combinational one-cycle strobe on the edge where the debounced state
// goes released -> pressed, so the consumer acts on that same edge.
module key_updown_counter_deb #(
  parameter int unsigned DEB_CYCLES     = 20000,
  parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic press
);

  // The counter never holds DEB_CYCLES itself: the edge that would reach it
  // flips the state and clears instead, so values 0..DEB_CYCLES-1 suffice.
  localparam int unsigned   CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic          RELEASED = KEY_ACTIVE_LOW;

  logic          sync1;
  logic          sync2;
  logic          deb_pressed;
  logic [CW-1:0] cnt;
  logic          raw_pressed;
  logic          differs;
  logic          flip;

  assign raw_pressed = (sync2 != RELEASED);
  assign differs     = (raw_pressed != deb_pressed);
  assign flip        = differs && (cnt == CNT_LAST);
  assign press       = flip && !deb_pressed;

  // Two-flop synchroniser; reset loads the released level so a key held
  // through reset is seen as a fresh press afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= RELEASED;
      sync2 <= RELEASED;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  // Debounce: count consecutive edges the synchronised key disagrees with the
  // debounced state; any agreement (a bounce) restarts the count from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_pressed <= 1'b0;
      cnt         <= '0;
    end else if (!differs) begin
      cnt <= '0;
    end else if (flip) begin
      deb_pressed <= ~deb_pressed;
      cnt         <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

module key_updown_counter #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned DEB_CYCLES     = 20000,
  parameter int unsigned INIT_VALUE     = 8'hFF,
  parameter bit          SATURATE       = 1'b0,
  parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             KeyUp,
  input  logic             KeyDown,
  input  logic             KeyClr,
  output logic [WIDTH-1:0] LED,
  output logic             Carry,
  output logic             Borrow
);

  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT_VALUE);
  localparam logic [WIDTH-1:0] MAX_V  = '1;

  logic             up_press;
  logic             down_press;
  logic             clr_press;
  logic [WIDTH-1:0] led_next;
  logic             carry_next;
  logic             borrow_next;

  key_updown_counter_deb #(
    .DEB_CYCLES     (DEB_CYCLES),
    .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
  ) u_deb_up (
    .clk     (CLK),
    .rst_n   (Reset),
    .key_raw (KeyUp),
    .press   (up_press)
  );

  key_updown_counter_deb #(
    .DEB_CYCLES     (DEB_CYCLES),
    .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
  ) u_deb_down (
    .clk     (CLK),
    .rst_n   (Reset),
    .key_raw (KeyDown),
    .press   (down_press)
  );

  key_updown_counter_deb #(
    .DEB_CYCLES     (DEB_CYCLES),
    .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
  ) u_deb_clr (
    .clk     (CLK),
    .rst_n   (Reset),
    .key_raw (KeyClr),
    .press   (clr_press)
  );

  // Next count and event pulses; clear wins, simultaneous up+down cancel,
  // and the limit cases either wrap or hold but always raise their pulse.
  always_comb begin
    led_next    = LED;
    carry_next  = 1'b0;
    borrow_next = 1'b0;
    if (clr_press) begin
      led_next = INIT_W;
    end else if (up_press && down_press) begin
      led_next = LED;
    end else if (up_press) begin
      if (LED == MAX_V) begin
        carry_next = 1'b1;
        led_next   = SATURATE ? MAX_V : '0;
      end else begin
        led_next = LED + WIDTH'(1);
      end
    end else if (down_press) begin
      if (LED == '0) begin
        borrow_next = 1'b1;
        led_next    = SATURATE ? '0 : MAX_V;
      end else begin
        led_next = LED - WIDTH'(1);
      end
    end
  end

  // Registered count and one-cycle Carry/Borrow pulses.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      LED    <= INIT_W;
      Carry  <= 1'b0;
      Borrow <= 1'b0;
    end else begin
      LED    <= led_next;
      Carry  <= carry_next;
      Borrow <= borrow_next;
    end
  end

endmodule

// File: tb/tb_key_updown_counter.sv
// Bench for key_updown_counter: a wrap-mode instance (INIT F) and a
// saturate-mode instance (INIT 0), both WIDTH=4, DEB_CYCLES=4, active-low keys.
// Stimulus pushes {dut, cycle, led, carry, borrow} onto exp_q; the monitor
// pops an entry whenever a DUT's output tuple changes and compares it.
module tb_key_updown_counter;

  localparam int W  = 4;
  localparam int EW = 35 + W;  // {dut[0], cycle[31:0], led[W-1:0], carry, borrow}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] rst_n_tb = 2'b00;

  // key bit 0 = up, bit 1 = down, bit 2 = clear (active-low levels)
  logic [2:0]   key_w = 3'b111;
  logic [2:0]   key_s = 3'b111;
  logic [W-1:0] led_w, led_s;
  logic         carry_w, borrow_w, carry_s, borrow_s;

  key_updown_counter #(
    .WIDTH(4), .DEB_CYCLES(4), .INIT_VALUE(4'hF), .SATURATE(1'b0), .KEY_ACTIVE_LOW(1'b1)
  ) dut_w (
    .CLK(clk), .Reset(rst_n_tb[0]),
    .KeyUp(key_w[0]), .KeyDown(key_w[1]), .KeyClr(key_w[2]),
    .LED(led_w), .Carry(carry_w), .Borrow(borrow_w)
  );

  key_updown_counter #(
    .WIDTH(4), .DEB_CYCLES(4), .INIT_VALUE(4'h0), .SATURATE(1'b1), .KEY_ACTIVE_LOW(1'b1)
  ) dut_s (
    .CLK(clk), .Reset(rst_n_tb[1]),
    .KeyUp(key_s[0]), .KeyDown(key_s[1]), .KeyClr(key_s[2]),
    .LED(led_s), .Carry(carry_s), .Borrow(borrow_s)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  bit fin_req = 1'b0;
  bit fin_ack = 1'b0;

  // ---------------- driver tasks ----------------
  task automatic set_keys(input int d, input logic [2:0] mask);
    if (d == 0) key_w = ~mask;
    else        key_s = ~mask;
  endtask

  // Press the keys in 'mask' for 'hold' cycles starting at this negedge.
  // A change is expected 6 edges later (2 sync + 4 debounce); a pulse adds
  // a second entry one cycle later when the pulse drops.
  task automatic press(input int d, input logic [2:0] mask, input int hold,
                       input bit chg, input logic [W-1:0] led,
                       input logic c, input logic b);
    int n;
    n = cyc;
    set_keys(d, mask);
    if (chg) begin
      exp_q.push_back({d[0], 32'(n + 6), led, c, b});
      if (c || b) exp_q.push_back({d[0], 32'(n + 7), led, 1'b0, 1'b0});
    end
    repeat (hold) @(negedge clk);
    set_keys(d, 3'b000);
    repeat (10) @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W+1:0]  prev [2];
    logic [W+1:0]  cur;
    logic [W+1:0]  rv;
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    prev[0] = {4'hF, 2'b00};
    prev[1] = {4'h0, 2'b00};
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        cur = (d == 0) ? {led_w, carry_w, borrow_w} : {led_s, carry_s, borrow_s};
        rv  = (d == 0) ? {4'hF, 2'b00} : {4'h0, 2'b00};
        if (!rst_n_tb[d]) begin
          n_cmp++;
          if (cur !== rv) begin
            n_err++;
            $display("FAIL reset_state dut%0d cyc=%0d: got led=%h c=%b b=%b, want led=%h c=0 b=0",
                     d, cyc, cur[W+1:2], cur[1], cur[0], rv[W+1:2]);
          end
          prev[d] = cur;
        end else if (cur !== prev[d]) begin
          prev[d] = cur;
          got = {d[0], 32'(cyc), cur};
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_change dut%0d cyc=%0d: got led=%h c=%b b=%b, want no change",
                     d, cyc, cur[W+1:2], cur[1], cur[0]);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              n_err++;
              $display("FAIL output_change: got dut%0d cyc=%0d led=%h c=%b b=%b, want dut%0d cyc=%0d led=%h c=%b b=%b",
                       got[EW-1], got[EW-2:W+2], got[W+1:2], got[1], got[0],
                       e[EW-1], e[EW-2:W+2], e[W+1:2], e[1], e[0]);
            end
          end
        end
      end
      if (fin_req && !fin_ack) begin
        n_cmp++;
        if (exp_q.size() != 0) begin
          n_err++;
          $display("FAIL missing_changes: got %0d expected entries never seen, want 0", exp_q.size());
        end
        fin_ack = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int m;
    repeat (4) @(negedge clk);
    rst_n_tb = 2'b11;
    repeat (4) @(negedge clk);

    // Clean down press F->E, then five more -> 9
    press(0, 3'b010, 10, 1, 4'hE, 1'b0, 1'b0);
    press(0, 3'b010, 10, 1, 4'hD, 1'b0, 1'b0);
    press(0, 3'b010, 10, 1, 4'hC, 1'b0, 1'b0);
    press(0, 3'b010, 10, 1, 4'hB, 1'b0, 1'b0);
    press(0, 3'b010, 10, 1, 4'hA, 1'b0, 1'b0);
    press(0, 3'b010, 10, 1, 4'h9, 1'b0, 1'b0);

    // Bounce: toggle every 2 cycles for 20 cycles, then hold low -> 8
    for (int k = 0; k < 10; k++) begin
      key_w[1] = k[0];
      repeat (2) @(negedge clk);
    end
    key_w[1] = 1'b0;
    exp_q.push_back({1'b0, 32'(cyc + 6), 4'h8, 1'b0, 1'b0});
    repeat (10) @(negedge clk);
    key_w[1] = 1'b1;
    repeat (10) @(negedge clk);

    // 3-cycle glitch: no effect
    key_w[1] = 1'b0;
    repeat (3) @(negedge clk);
    key_w[1] = 1'b1;
    repeat (10) @(negedge clk);

    // Down to 1, then 0, then wrap to F with Borrow; up wraps to 0 with Carry
    for (int v = 7; v >= 1; v--) press(0, 3'b010, 10, 1, 4'(v), 1'b0, 1'b0);
    press(0, 3'b010, 10, 1, 4'h0, 1'b0, 1'b0);
    press(0, 3'b010, 10, 1, 4'hF, 1'b0, 1'b1);
    press(0, 3'b001, 10, 1, 4'h0, 1'b1, 1'b0);

    // Up+down together: no change; clear+up together: INIT
    press(0, 3'b011, 10, 0, 4'h0, 1'b0, 1'b0);
    press(0, 3'b101, 10, 1, 4'hF, 1'b0, 1'b0);
    press(0, 3'b010, 10, 1, 4'hE, 1'b0, 1'b0);

    // Reset at debounce count 2, key released during reset: no count
    n = cyc;
    key_w[1] = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n_tb[0] = 1'b0;
    @(negedge clk);
    key_w[1] = 1'b1;
    repeat (3) @(negedge clk);
    rst_n_tb[0] = 1'b1;
    repeat (12) @(negedge clk);

    // Reset at debounce count 2, key still held: one count 6 edges after release
    key_w[1] = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n_tb[0] = 1'b0;
    repeat (3) @(negedge clk);
    m = cyc;
    rst_n_tb[0] = 1'b1;
    exp_q.push_back({1'b0, 32'(m + 6), 4'hE, 1'b0, 1'b0});
    repeat (10) @(negedge clk);
    key_w[1] = 1'b1;
    repeat (10) @(negedge clk);

    // Saturate instance: down at 0 holds with Borrow; 16 ups end at F with
    // a Carry only on the 16th
    press(1, 3'b010, 10, 1, 4'h0, 1'b0, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) press(1, 3'b001, 10, 1, 4'hF, 1'b1, 1'b0);
      else         press(1, 3'b001, 10, 1, 4'(i), 1'b0, 1'b0);
    end

    if (n < 0) $display("cycle counter wrapped");
    fin_req = 1'b1;
    wait (fin_ack);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
